// File: rtl/cell_output_scheduler.sv
// cell_output_scheduler: round-robin arbiter feeding one byte-serial
// cell serializer, with per-port enables, a sent counter and start timeout.
module cell_output_scheduler #(
  parameter int N_PORTS  = 4,
  parameter int CELL_W   = 53,
  parameter int START_TO = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_valid,
  input  logic [N_PORTS*CELL_W-1:0]   req_cell,
  output logic [N_PORTS-1:0]          req_ready,
  input  logic [N_PORTS-1:0]          port_en,
  input  logic                        ser_busy,
  output logic [CELL_W-1:0]           cell_out,
  output logic                        cell_valid,
  output logic [15:0]                 cells_sent,
  output logic                        err_start,
  input  logic                        err_clr
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    DRAIN
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [3:0]        timer;
  logic [15:0]       cnt;
  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] grant_oh;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     cand;
  logic              grant_any;
  logic              go;

  assign elig       = req_valid & port_en;
  assign go         = (state == IDLE) && !ser_busy && grant_any;
  assign req_ready  = go ? grant_oh : '0;
  assign cells_sent = cnt;

  // Scan upward from the port after the last winner, wrapping at N_PORTS.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr;
    grant_oh  = '0;
    cand      = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = PW'((int'(ptr) + k) % N_PORTS);
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  // Grant / issue / start-watch / drain sequencing with registered outputs.
  // The start check fires once the incremented timer would reach
  // START_TO-1, so the error shows START_TO cycles after the issue strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= PW'(N_PORTS - 1);
      timer      <= '0;
      cnt        <= '0;
      cell_out   <= '0;
      cell_valid <= 1'b0;
      err_start  <= 1'b0;
    end else begin
      cell_valid <= 1'b0;
      if (err_clr) err_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            cell_out   <= req_cell[int'(grant_idx)*CELL_W +: CELL_W];
            ptr        <= grant_idx;
            cell_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (ser_busy) begin
            state <= DRAIN;
          end else if (int'(timer) + 2 >= START_TO) begin
            err_start <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        DRAIN: begin
          if (!ser_busy) begin
            cnt   <= cnt + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_output_scheduler.sv
// tb_cell_output_scheduler: scenario tasks plus randomized rounds checked
// against a round-robin reference model and a simple serializer model.
module tb_cell_output_scheduler;

  localparam int N  = 4;
  localparam int W  = 53;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_cell;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   port_en = '1;
  logic           ser_busy;
  logic [W-1:0]   cell_out;
  logic           cell_valid;
  logic [15:0]    cells_sent;
  logic           err_start;
  logic           err_clr = 1'b0;

  logic [W-1:0]   cells [N];

  int vec  = 0;
  int errs = 0;
  int viol = 0;
  int ser_len = 53;
  bit ser_on  = 1'b1;

  cell_output_scheduler #(
    .N_PORTS(N), .CELL_W(W), .START_TO(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cell(req_cell),
    .req_ready(req_ready), .port_en(port_en),
    .ser_busy(ser_busy), .cell_out(cell_out),
    .cell_valid(cell_valid), .cells_sent(cells_sent),
    .err_start(err_start), .err_clr(err_clr)
  );

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign req_cell[i*W +: W] = cells[i];
  end

  always #5 clk = ~clk;

  // Serializer: busy for ser_len cycles starting one cycle after issue.
  initial begin
    ser_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cell_valid && ser_on) begin
        @(posedge clk); #1 ser_busy = 1'b1;
        repeat (ser_len) @(posedge clk);
        #1 ser_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) if (cell_valid && ser_busy) viol++;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errs=%0d", errs);
    $fatal(1);
  end

  function automatic logic [W-1:0] rand_cell();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic wait_cycles_grant(output logic [N-1:0] g);
    int i;
    #1 g = req_ready;
    i = 0;
    while (g == '0 && i < 200) begin
      @(negedge clk); #1 g = req_ready; i++;
    end
  endtask

  task automatic do_cell(input bit drop, input logic [N-1:0] en_after,
                         output logic [N-1:0] g, output logic [W-1:0] c,
                         output logic cv, output bit ok);
    int i;
    ok = 1'b1; cv = 1'b0; c = '0;
    wait_cycles_grant(g);
    if (g == '0) begin ok = 1'b0; return; end
    @(posedge clk); #1;
    if (drop) req_valid = req_valid & ~g;
    @(negedge clk);
    cv = cell_valid; c = cell_out;
    i = 0;
    while (!ser_busy && i < 50) begin @(negedge clk); i++; end
    i = 0;
    while (ser_busy && i < 200) begin
      @(negedge clk); port_en = en_after; i++;
    end
    if (ser_busy || i == 0) ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; port_en = '1; err_clr = 1'b0;
    for (int i = 0; i < N; i++) cells[i] = rand_cell();
    repeat (2) @(negedge clk);
    vec++; if (req_ready !== '0) begin errs++;
      $display("FAIL rst_ready got=%b exp=0", req_ready); end
    vec++; if (cell_valid !== 1'b0) begin errs++;
      $display("FAIL rst_valid got=%b exp=0", cell_valid); end
    vec++; if (cell_out !== '0) begin errs++;
      $display("FAIL rst_cell got=%h exp=0", cell_out); end
    vec++; if (cells_sent !== 16'd0) begin errs++;
      $display("FAIL rst_cnt got=%0d exp=0", cells_sent); end
    vec++; if (err_start !== 1'b0) begin errs++;
      $display("FAIL rst_err got=%b exp=0", err_start); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] g; logic [W-1:0] c; logic cv; bit ok;
    cells[2] = 53'h1ABCD; req_valid = 4'b0100; ser_len = 53;
    do_cell(1'b1, '1, g, c, cv, ok);
    vec++; if (!ok) begin errs++; $display("FAIL single_timeout"); end
    vec++; if (g !== 4'b0100) begin errs++;
      $display("FAIL single_grant got=%b exp=0100", g); end
    vec++; if (cv !== 1'b1) begin errs++;
      $display("FAIL single_valid got=%b exp=1", cv); end
    vec++; if (c !== 53'h1ABCD) begin errs++;
      $display("FAIL single_cell got=%h exp=1abcd", c); end
    vec++; if (cells_sent !== 16'd1) begin errs++;
      $display("FAIL single_cnt got=%0d exp=1", cells_sent); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g; logic [W-1:0] c; logic cv; bit ok;
    int exp_p;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) cells[i] = rand_cell();
    req_valid = '1; port_en = '1; viol = 0;
    for (int k = 0; k < 6; k++) begin
      exp_p = k % N;
      do_cell(1'b0, '1, g, c, cv, ok);
      vec++; if (!ok || g !== N'(1 << exp_p) || c !== cells[exp_p]) begin
        errs++;
        $display("FAIL rr_%0d got=%b/%h exp=%b/%h ok=%0d", k, g, c,
                 N'(1 << exp_p), cells[exp_p], ok);
      end
    end
    vec++; if (viol !== 0) begin errs++;
      $display("FAIL rr_overlap got=%0d exp=0", viol); end
    vec++; if (cells_sent !== 16'd6) begin errs++;
      $display("FAIL rr_cnt got=%0d exp=6", cells_sent); end
    req_valid = '0;
  endtask

  task automatic test_port_enable();
    logic [N-1:0] g; logic [W-1:0] c; logic cv; bit ok;
    logic [N-1:0] ena [4];
    logic [N-1:0] expg [4];
    ena  = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
    expg = '{4'b1000, 4'b1000, 4'b1000, 4'b0010};
    req_valid = 4'b1010; port_en = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      do_cell(1'b0, ena[k], g, c, cv, ok);
      vec++; if (!ok || g !== expg[k]) begin errs++;
        $display("FAIL en_%0d got=%b exp=%b ok=%0d", k, g, expg[k], ok);
      end
    end
    req_valid = '0; port_en = '1;
  endtask

  task automatic test_start_timeout();
    logic [N-1:0] g; logic [15:0] prev;
    ser_on = 1'b0; prev = cells_sent;
    req_valid = 4'b0100;
    wait_cycles_grant(g);
    @(posedge clk); @(negedge clk);
    vec++; if (cell_valid !== 1'b1) begin errs++;
      $display("FAIL to_issue got=%b exp=1", cell_valid); end
    err_clr = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (err_start !== 1'b0) begin errs++;
      $display("FAIL to_early got=%b exp=0", err_start); end
    @(negedge clk);
    vec++; if (err_start !== 1'b1) begin errs++;
      $display("FAIL to_set got=%b exp=1", err_start); end
    vec++; if (req_ready !== 4'b0100) begin errs++;
      $display("FAIL to_idle got=%b exp=0100", req_ready); end
    vec++; if (cells_sent !== prev) begin errs++;
      $display("FAIL to_cnt got=%0d exp=%0d", cells_sent, prev); end
    req_valid = '0;
    @(negedge clk);
    vec++; if (err_start !== 1'b0) begin errs++;
      $display("FAIL to_clr got=%b exp=0", err_start); end
    err_clr = 1'b0; ser_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g; logic [W-1:0] c; logic cv; bit ok;
    int i;
    ser_len = 53; req_valid = 4'b0100;
    wait_cycles_grant(g);
    @(posedge clk); #1 req_valid = '0;
    i = 0;
    while (!ser_busy && i < 20) begin @(negedge clk); i++; end
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    vec++; if (cells_sent !== 16'd0 || cell_out !== '0) begin errs++;
      $display("FAIL mid_rst cnt=%0d cell=%h exp=0/0", cells_sent, cell_out);
    end
    vec++; if (cell_valid !== 1'b0 || err_start !== 1'b0) begin errs++;
      $display("FAIL mid_rst_flags got=%b%b exp=00", cell_valid, err_start);
    end
    @(negedge clk); rst = 1'b0; req_valid = '1;
    i = 0;
    while (ser_busy && i < 100) begin
      @(negedge clk); i++;
      if (cell_valid) ok = 1'b0;
    end
    #1;
    vec++; if (req_ready !== 4'b0001 || cell_valid !== 1'b0) begin errs++;
      $display("FAIL mid_first got=%b/%b exp=0001/0", req_ready, cell_valid);
    end
    do_cell(1'b1, '1, g, c, cv, ok);
    vec++; if (!ok || g !== 4'b0001 || cells_sent !== 16'd1) begin errs++;
      $display("FAIL mid_cell got=%b cnt=%0d exp=0001/1", g, cells_sent);
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    logic [N-1:0] g; logic [W-1:0] c; logic cv; bit ok;
    force dut.cnt = 16'hFFFF;
    @(negedge clk);
    release dut.cnt;
    @(negedge clk);
    vec++; if (cells_sent !== 16'hFFFF) begin errs++;
      $display("FAIL wrap_pre got=%h exp=ffff", cells_sent); end
    req_valid = 4'b0010;
    do_cell(1'b1, '1, g, c, cv, ok);
    vec++; if (!ok || cells_sent !== 16'h0000) begin errs++;
      $display("FAIL wrap got=%h exp=0000 ok=%0d", cells_sent, ok); end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] g; logic [W-1:0] c; logic cv; bit ok, seen;
    logic [N-1:0] v, e, el;
    int ptr_m, cnt_m, p;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    ptr_m = N - 1; cnt_m = 0;
    for (int r = 0; r < 40; r++) begin
      v = N'($urandom_range(1, 15));
      e = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) cells[i] = rand_cell();
      ser_len = $urandom_range(1, 6);
      req_valid = v; port_en = e; el = v & e;
      if (el == '0) begin
        seen = 1'b0;
        repeat (6) begin
          #1 if (req_ready != '0) seen = 1'b1;
          @(negedge clk);
        end
        vec++; if (seen) begin errs++;
          $display("FAIL rnd_%0d_nogrant v=%b e=%b", r, v, e); end
      end else begin
        p = -1;
        for (int k = 1; k <= N && p < 0; k++)
          if (el[(ptr_m + k) % N]) p = (ptr_m + k) % N;
        do_cell(1'b1, e, g, c, cv, ok);
        cnt_m++;
        vec++;
        if (!ok || g !== N'(1 << p) || c !== cells[p] || cv !== 1'b1
            || cells_sent !== 16'(cnt_m)) begin
          errs++;
          $display("FAIL rnd_%0d got=%b/%h/%0d exp=%b/%h/%0d ok=%0d", r, g,
                   c, cells_sent, N'(1 << p), cells[p], cnt_m, ok);
        end
        ptr_m = p;
      end
    end
    req_valid = '0; port_en = '1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_port_enable();
    test_start_timeout();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/cell_output_scheduler.md
Name: cell_output_scheduler

Overview:
Round-robin scheduler that shares the byte-serial cell output interface among N_PORTS cell sources. It grants one pending source and latches its cell. It then presents the cell to the serializer as a single-cycle valid pulse and holds off further grants until the serializer reports completion. It sits between the per-port cell queues and the output serializer. It also provides a per-port enable mask, a sent-cell counter and a sticky error flag when the serializer fails to start.

Parameters:
N_PORTS, 4, number of requesting cell sources (2..16)
CELL_W, 53, cell width in bits; must match the serializer cell input
START_TO, 4, cycles allowed after issue for ser_busy to rise (1..15)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
req_valid  input  N_PORTS  per-port cell pending
req_cell  input  N_PORTS*CELL_W  per-port cell; port i occupies bits [i*CELL_W +: CELL_W]
req_ready  output  N_PORTS  one-hot grant; transfer on req_valid[i] & req_ready[i]
port_en  input  N_PORTS  per-port enable; a disabled port is never granted
ser_busy  input  1  serializer active (its valid_out)
cell_out  output  CELL_W  cell to serializer
cell_valid  output  1  one-cycle issue strobe to serializer
cells_sent  output  16  count of cells completed by the serializer
err_start  output  1  sticky: serializer did not start within START_TO
err_clr  input  1  clears err_start

Behaviour:
- Reset values:
  - All registered outputs 0.
  - FSM = IDLE; RR pointer = N_PORTS-1, so port 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT_START, DRAIN.
- IDLE:
  - Eligible set = req_valid & port_en.
  - If ser_busy = 0 and the eligible set is non-empty, grant the first eligible port scanning from pointer+1 upward, with modulo N_PORTS wrap.
  - req_ready is combinational: one-hot grant, only in IDLE with ser_busy = 0; otherwise all zeros.
  - On the grant edge:
    - cell_out <= granted slice.
    - pointer <= granted index.
    - go to ISSUE.
  - With no eligible port, or ser_busy = 1, remain in IDLE; the pointer is unchanged.
- ISSUE:
  - cell_valid = 1 for exactly this cycle.
  - Timer <= 0; go to WAIT_START.
  - Latency: grant edge to cell_valid high is 1 cycle.
- WAIT_START:
  - If ser_busy = 1, go to DRAIN.
  - Otherwise increment the timer.
  - When the timer reaches START_TO-1 with ser_busy still 0: set err_start, return to IDLE, and do not count the cell.
- DRAIN:
  - Wait for ser_busy = 0.
  - On that cycle: cells_sent += 1, wrapping 0xFFFF -> 0, and go to IDLE.
- Grant gap: the next grant can occur in the cycle after entering IDLE.
- Pointer update: only on an actual grant. Consequently a port withdrawing req_valid while another is served does not lose priority order.
- port_en changes take effect combinationally in IDLE. Clearing an enable in any other state does not abort the cell in flight.
- cell_out holds its value after issue until the next grant.
- err_start:
  - err_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Reset asserted mid-operation:
  - Immediate return to IDLE; outputs cleared; counter cleared.
  - No partial cell is reissued after reset.
- req_valid with all port_en = 0: no grant, the FSM stays in IDLE indefinitely.

Test Plan:
1. Single port 2 valid with cell 0x1ABCD, ser_busy modelled high for 53 cycles starting 1 cycle after cell_valid -> req_ready = 0100 for 1 cycle; cell_valid 1 cycle later with cell_out = 0x1ABCD; cells_sent = 1 after ser_busy falls.
2. All 4 ports valid continuously, serializer model as in test 1 -> grant order 0,1,2,3,0,1; each port served exactly once per 4 cells; no cell_valid while ser_busy = 1.
3. Ports 1 and 3 valid, port_en = 1101 -> only port 3 is granted, repeatedly. Set port_en[1] mid-DRAIN -> the next grant goes to port 1, since the pointer is 3 and the scan wraps to 0 then 1.
4. ser_busy stuck 0 after issue, START_TO = 4 -> err_start rises 4 cycles after cell_valid; FSM back in IDLE; cells_sent unchanged. Pulse err_clr -> err_start = 0.
5. Assert rst during DRAIN -> all outputs 0 and cells_sent = 0 immediately. After release, with port 0 valid, the grant goes to port 0.
6. Preload cells_sent = 0xFFFF by running 65535 cells, or via a forced bench path -> the next completion wraps it to 0x0000.
